// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the one-hot select of a shared 4:1 32-bit data mux.
// Latency: grant is registered, 1 cycle from req sampled to grant; handoff has no idle bubble.
// Backpressure: requesters hold req for the whole transfer; an owner is rotated out after MAX_HOLD cycles under contention.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] grant,
    output logic       busy,
    output logic [1:0] owner,
    output logic       xfer
);

    typedef enum logic {
        S_IDLE,
        S_GRANTED
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_nxt;
    logic             r_busy;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [3:0]       w_others;
    logic             w_own_req;
    logic             w_own_last;
    logic             w_release;
    logic [1:0]       w_pick_req;
    logic [1:0]       w_pick_oth;

    // Index i maps to req bit 3-i; search starts just after 'after' and wraps back to it last.
    function automatic logic [1:0] f_pick(input logic [3:0] mask, input logic [1:0] after);
        logic [1:0] idx;
        logic       found;
        f_pick = after;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = after + 2'(k);
            if (!found && mask[~idx]) begin
                f_pick = idx;
                found  = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        f_onehot = 4'b1000 >> idx;
    endfunction

    assign w_others   = req & ~r_grant;
    assign w_own_req  = |(req & r_grant);
    assign w_own_last = |(req & last & r_grant);
    assign w_release  = !w_own_req || w_own_last;
    assign w_pick_req = f_pick(req, r_owner);
    assign w_pick_oth = f_pick(w_others, r_owner);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANTED;
                    w_owner_nxt = w_pick_req;
                    w_grant_nxt = f_onehot(w_pick_req);
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANTED: begin
                if (w_release) begin
                    w_cnt_nxt = '0;
                    if (|w_others) begin
                        w_owner_nxt = w_pick_oth;
                        w_grant_nxt = f_onehot(w_pick_oth);
                    end else if (!w_own_last) begin
                        // Sole requester finishing on last is simply re-granted; otherwise go idle.
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else if (r_cnt == C_HOLD_MAX && |w_others) begin
                    w_owner_nxt = w_pick_oth;
                    w_grant_nxt = f_onehot(w_pick_oth);
                    w_cnt_nxt   = '0;
                end else if (r_cnt < C_HOLD_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_owner <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= |w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign owner = r_owner;
    assign xfer  = |(r_grant & req);

    a_req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
    a_busy_match: assert property (@(posedge clk) disable iff (!rst_n) r_busy == (|r_grant));

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 4:1 one-hot-select data mux among four requesters.
- Drives the mux select directly with a registered one-hot grant: 4'b1000 selects input 1, 4'b0100 input 2, 4'b0010 input 3, 4'b0001 input 4.
- Drives 4'b0000 when idle, so the mux output is high-Z.
- Enforces fairness with a bounded hold time and supports burst release through a per-requester last flag.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles an owner may keep the mux while another requester is waiting. Legal range is 1..255.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request vector. Bit 3 = requester 1 (mux input 1) … bit 0 = requester 4 (mux input 4). Held high for the whole transfer.
- last  input  4  per-requester final-beat flag. Only meaningful while the same bit of req and grant is high.
- grant  output  4  registered one-hot grant, 4'b0000 when idle. Wired to the mux select.
- busy  output  1  registered; 1 while grant != 0.
- owner  output  2  registered index of the current or most recent owner: 0 = requester 1 … 3 = requester 4.
- xfer  output  1  combinational, |(grant & req). Marks a cycle in which mux data is valid for the owner.

Behaviour:
- Reset (async, rst_n low): grant=4'b0000, busy=0, owner=3, hold counter=0.
  - owner=3 makes requester 1 (bit 3) the first in search order after reset.
  - Asserting reset mid-transfer clears grant immediately, without waiting for a clock edge.
- Search order: circular, starting at the requester after owner: 1→2→3→4→1. The first requester with req high wins.
- States:
  - IDLE (grant=0)
  - GRANTED (grant one-hot)
- IDLE → GRANTED: at a clock edge where req != 0.
  - grant = winner's one-hot code; owner = winner index; counter = 0.
  - Latency: 1 cycle from req sampled high to grant high.
- GRANTED, at each clock edge with owner bit = o:
  - Release: req[o]=0, or req[o]&last[o]=1.
    - If another req bit is high, grant the next requester in search order at the same edge (no idle bubble).
    - Else go to IDLE: grant=0, owner unchanged.
    - The releasing requester takes part in the search only when it is the sole requester and the release was caused by last; it is then re-granted.
  - Preempt: no release, counter == MAX_HOLD-1, and (req & ~grant) != 0.
    - Rotate to the next requester in search order; counter = 0.
  - Otherwise: keep grant; counter increments, saturating at MAX_HOLD-1.
    - With no competitor, the owner keeps the mux indefinitely.
- Timing of xfer: grant is registered, so on the cycle after req drops, grant may still point at the old owner while xfer=0. Requesters count data only on xfer cycles.
- MAX_HOLD=1: with contention, ownership rotates every cycle.
- Invariants:
  - grant is always 0 or one-hot.
  - grant never changes to a requester whose req was low at the sampling edge.
  - busy == |grant.
  - A requester holding req high waits at most 3*MAX_HOLD cycles for grant.
- X/Z on req after reset is a verification error. Assertions must flag it.

Test Plan:
1. Reset then req=4'b0010 at cycle 2 → grant=4'b0010, owner=2, busy=1 at cycle 3. Drop req at cycle 6 → grant=0, busy=0 at cycle 7.
2. Simultaneous req=4'b1111 held, last=0, MAX_HOLD=8 → grant 1000 for 8 cycles, then 0100 ×8, 0010 ×8, 0001 ×8, then 1000 again. Exactly one bit set every cycle.
3. Back-to-back handoff: owner 1000, req=4'b1001, last[3] pulsed at cycle 5 → grant=4'b0001 at cycle 6, with no zero-grant cycle between.
4. Sole requester 0100, held 40 cycles with last=0 → grant stays 0100 for all 40 cycles; no preemption.
5. MAX_HOLD=1, req=4'b1010 held → grant alternates 1000,0010,1000,… every cycle.
6. Owner 0010 mid-transfer, rst_n low between clock edges → grant=0, busy=0 immediately. After release, req=4'b0011 → requester 1's slot is skipped and grant=4'b0010 first, since owner reset to 3.
